// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared constants and types for the SPI responder slice.
//               SPI_FRAME_BITS  - default frame length in bits
//               SPI_SYNC_STAGES - default synchronizer depth
//               spi_rsp_state_t - responder FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

  localparam int SPI_FRAME_BITS  = 40;
  localparam int SPI_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } spi_rsp_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Multi-flop synchronizer for one asynchronous input, followed
//               by a registered edge detector.
//   clk   in   system clock
//   rst_n in   asynchronous active-low reset
//   din   in   asynchronous input pin
//   level out  synchronized level (STAGES clk after the pin)
//   rise  out  one-cycle strobe, STAGES+1 clk after a pin rising edge
//   fall  out  one-cycle strobe, STAGES+1 clk after a pin falling edge
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] r_sync;
  logic              r_prev;
  logic              r_rise;
  logic              r_fall;
  logic              w_level;

  assign w_level = r_sync[STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], din};
      r_prev <= w_level;
      r_rise <= w_level & ~r_prev;
      r_fall <= ~w_level & r_prev;
    end
  end

  assign level = w_level;
  assign rise  = r_rise;
  assign fall  = r_fall;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : spi_responder
// Description : SPI mode-0 slave emulating the joystick end of the bus.
//               Shifts in one WIDTH-bit frame MSB-first on mosi and shifts
//               out the reply word captured from tx_bytes at frame start.
//   clk       in   50 MHz system clock
//   rst_n     in   asynchronous active-low reset
//   tx_bytes  in   reply word, captured at frame start
//   rx_bytes  out  last complete received frame
//   rx_valid  out  one-cycle pulse when rx_bytes updates
//   frame_err out  one-cycle pulse when cs is released early
//   overrun   out  sticky: extra sck rising edges after a full frame
//   busy      out  frame in progress
//   cs        in   active-low chip select
//   sck       in   SPI clock
//   mosi      in   master-out data
//   miso      out  slave-out data
//   miso_oe   out  miso pad enable (synchronized ~cs)
// Revision    : 1.0 - initial release
// ============================================================================
module spi_responder
  import spi_pkg::*;
#(
  parameter int WIDTH       = SPI_FRAME_BITS,
  parameter int SYNC_STAGES = SPI_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_bytes,
  output logic [WIDTH-1:0] rx_bytes,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy,
  input  logic             cs,
  input  logic             sck,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe
);

  localparam int                CNT_W      = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  C_LAST_BIT = CNT_W'(WIDTH - 1);
  localparam int                SETTLE_LEN = SYNC_STAGES + 2;

  // --------------------------------------------------------------------------
  // Input synchronizers
  // --------------------------------------------------------------------------
  logic w_cs_level, w_cs_rise, w_cs_fall;
  logic w_sck_level_unused, w_sck_rise, w_sck_fall;
  logic w_mosi, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (cs),
    .level (w_cs_level),
    .rise  (w_cs_rise),
    .fall  (w_cs_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (sck),
    .level (w_sck_level_unused),
    .rise  (w_sck_rise),
    .fall  (w_sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (mosi),
    .level (w_mosi),
    .rise  (w_mosi_rise_unused),
    .fall  (w_mosi_fall_unused)
  );

  // --------------------------------------------------------------------------
  // Post-reset arming. The cs synchronizer resets to "high", so a cs pin that
  // is already low at reset release would look like a falling edge. Frames are
  // only accepted once the pipeline holds real samples and cs was seen high.
  // --------------------------------------------------------------------------
  logic [SETTLE_LEN-1:0] r_settle;
  logic                  r_armed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_settle <= '0;
      r_armed  <= 1'b0;
    end else begin
      r_settle <= {r_settle[SETTLE_LEN-2:0], 1'b1};
      r_armed  <= r_armed | (r_settle[SETTLE_LEN-1] & w_cs_level);
    end
  end

  // --------------------------------------------------------------------------
  // FSM and datapath
  // --------------------------------------------------------------------------
  spi_rsp_state_t   r_state,     w_state_nxt;
  logic [CNT_W-1:0] r_bit_cnt,   w_bit_cnt_nxt;
  logic [WIDTH-1:0] r_tx_sr,     w_tx_sr_nxt;
  logic [WIDTH-1:0] r_rx_sr,     w_rx_sr_nxt;
  logic [WIDTH-1:0] r_rx_bytes,  w_rx_bytes_nxt;
  logic             r_rx_valid,  w_rx_valid_nxt;
  logic             r_frame_err, w_frame_err_nxt;
  logic             r_overrun,   w_overrun_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_tx_sr     <= '0;
      r_rx_sr     <= '0;
      r_rx_bytes  <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_tx_sr     <= w_tx_sr_nxt;
      r_rx_sr     <= w_rx_sr_nxt;
      r_rx_bytes  <= w_rx_bytes_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_tx_sr_nxt     = r_tx_sr;
    w_rx_sr_nxt     = r_rx_sr;
    w_rx_bytes_nxt  = r_rx_bytes;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_overrun_nxt   = r_overrun;

    case (r_state)
      IDLE: begin
        // A coincident sck_rise is deliberately dropped: sck is low at cs fall
        if (w_cs_fall && r_armed) begin
          w_tx_sr_nxt   = tx_bytes;
          w_bit_cnt_nxt = '0;
          w_overrun_nxt = 1'b0;
          w_state_nxt   = SHIFT;
        end
      end

      SHIFT: begin
        if (w_cs_rise) begin
          w_frame_err_nxt = 1'b1;
          w_tx_sr_nxt     = '0;
          w_state_nxt     = IDLE;
        end else if (w_sck_rise) begin
          w_rx_sr_nxt   = {r_rx_sr[WIDTH-2:0], w_mosi};
          w_bit_cnt_nxt = r_bit_cnt + 1'b1;
          if (r_bit_cnt == C_LAST_BIT) begin
            w_rx_bytes_nxt = w_rx_sr_nxt;
            w_rx_valid_nxt = 1'b1;
            // Clearing the shifter holds miso at 0 for the rest of the frame
            w_tx_sr_nxt    = '0;
            w_state_nxt    = HOLD;
          end
        end else if (w_sck_fall) begin
          w_tx_sr_nxt = {r_tx_sr[WIDTH-2:0], 1'b0};
        end
      end

      HOLD: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
        end else if (w_sck_rise) begin
          w_overrun_nxt = 1'b1;
        end
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  assign rx_bytes  = r_rx_bytes;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != IDLE);
  assign miso      = r_tx_sr[WIDTH-1];
  assign miso_oe   = ~w_cs_level;

endmodule : spi_responder
`default_nettype wire

// File: tb/tb_spi_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_responder
// Description : Self-checking bench for spi_responder. A mode-0 master model
//               drives frames; received words are predicted into a queue and
//               popped when rx_valid fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_responder;

  localparam int W    = 40;
  localparam int HALF = 32;   // sck half-period in clk cycles (781.25 kHz)

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] tx_bytes;
  logic [W-1:0] rx_bytes;
  logic         rx_valid;
  logic         frame_err;
  logic         overrun;
  logic         busy;
  logic         cs;
  logic         sck;
  logic         mosi;
  logic         miso;
  logic         miso_oe;

  always #10 clk = ~clk;

  spi_responder #(.WIDTH(W), .SYNC_STAGES(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tx_bytes  (tx_bytes),
    .rx_bytes  (rx_bytes),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy),
    .cs        (cs),
    .sck       (sck),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int rx_cnt   = 0;
  int ferr_cnt = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (frame_err) ferr_cnt++;
      if (rx_valid) begin
        rx_cnt++;
        if (exp_q.size() == 0) begin
          check("rx_unexpected", 1, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("rx_bytes", rx_bytes, mon_exp);
        end
      end
    end
  end

  // One mode-0 frame: cs low, nbits sck pulses, cs high, then gap clk cycles
  task automatic run_frame(input logic [W-1:0] data, input logic [W-1:0] tx_exp,
                           input int nbits, input int gap);
    logic [W-1:0] mw;
    logic         extra;
    int           nb;
    mw    = '0;
    extra = 1'b0;
    if (nbits >= W) exp_q.push_back(data);
    cs   = 1'b0;
    mosi = data[W-1];
    repeat (HALF) @(negedge clk);
    check("ovr_clear", overrun, 0);
    check("busy_start", busy, 1);
    check("oe_on", miso_oe, 1);
    for (int i = 0; i < nbits; i++) begin
      if (i == W) check("ovr_before_41", overrun, 0);
      sck = 1'b1;
      if (i < W) mw[W-1-i] = miso;
      else       extra = extra | miso;
      if (i == W - 1) begin
        repeat (3) @(negedge clk);
        check("rxv_lat3", rx_valid, 0);
        @(negedge clk);
        check("rxv_lat4", rx_valid, 1);
        repeat (HALF - 4) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      sck  = 1'b0;
      mosi = (i + 1 < W) ? data[W-2-i] : 1'b0;
      repeat (HALF) @(negedge clk);
    end
    cs = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_cs3", busy, 1);
    @(negedge clk);
    check("busy_cs4", busy, 0);
    repeat (gap - 4) @(negedge clk);
    nb = (nbits < W) ? nbits : W;
    check("miso_word", mw >> (W - nb), tx_exp >> (W - nb));
    if (nbits > W) begin
      check("ovr_set", overrun, 1);
      check("miso_hold0", extra, 0);
    end
  endtask

  // Bare sck pulses with cs left as is (no expectations)
  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      mosi = i[0];
      repeat (HALF) @(negedge clk);
      sck = 1'b1;
      repeat (HALF) @(negedge clk);
      sck = 1'b0;
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    cs       = 1'b1;
    sck      = 1'b0;
    mosi     = 1'b0;
    tx_bytes = 40'hA5_0F_F0_3C_81;
    repeat (5) @(negedge clk);
    check("rst_rx_bytes", rx_bytes, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
    check("rst_miso", miso, 0);
    check("rst_miso_oe", miso_oe, 0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Normal frame
    run_frame(40'h12_34_56_78_9A, 40'hA5_0F_F0_3C_81, W, 20);
    check("normal_ferr", ferr_cnt, 0);
    check("normal_rxcnt", rx_cnt, 1);

    // Short frame: 17 bits
    tx_bytes = 40'h0F_1E_2D_3C_4B;
    run_frame(40'hCA_FE_BA_BE_00, 40'h0F_1E_2D_3C_4B, 17, 20);
    check("short_ferr", ferr_cnt, 1);
    check("short_rxcnt", rx_cnt, 1);
    check("short_rx_keep", rx_bytes, 40'h12_34_56_78_9A);

    // Overrun: 43 pulses
    tx_bytes = 40'h3C_3C_3C_3C_3C;
    run_frame(40'hDE_AD_BE_EF_01, 40'h3C_3C_3C_3C_3C, 43, 20);
    check("ovr_rxcnt", rx_cnt, 2);

    // Back-to-back frames with a 10 clk gap, reply changed in the gap
    tx_bytes = 40'h11_22_33_44_55;
    run_frame(40'h01_02_03_04_05, 40'h11_22_33_44_55, W, 10);
    tx_bytes = 40'hFF_FF_00_00_01;
    run_frame(40'h80_00_00_00_7F, 40'hFF_FF_00_00_01, W, 20);
    check("b2b_rxcnt", rx_cnt, 4);

    // Reset mid-frame with cs held low afterwards
    tx_bytes = 40'h55_55_55_55_55;
    cs = 1'b0;
    pulses(20);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mrst_busy", busy, 0);
    check("mrst_rx_bytes", rx_bytes, 0);
    check("mrst_miso", miso, 0);
    check("mrst_miso_oe", miso_oe, 0);
    check("mrst_overrun", overrun, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulses(W);
    repeat (HALF) @(negedge clk);
    check("mrst_no_rx", rx_cnt, 4);
    check("mrst_idle", busy, 0);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    run_frame(40'h0A_0B_0C_0D_0E, 40'h55_55_55_55_55, W, 20);
    check("mrst_rxcnt", rx_cnt, 5);

    // Loopback-style transfer from the 40-bit master
    tx_bytes = 40'h01_23_45_67_89;
    run_frame(40'h00_00_00_00_C3, 40'h01_23_45_67_89, W, 20);
    check("loop_rx", rx_bytes, 40'h00_00_00_00_C3);

    check("final_rxcnt", rx_cnt, 6);
    check("final_ferr", ferr_cnt, 1);
    check("final_q_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_spi_responder
`default_nettype wire

// File: doc/spi_responder.md
# spi_responder

SPI mode-0 (CPOL=0, CPHA=0) slave that emulates the joystick side of the bus so the on-chip SPI master and the game logic can be exercised without the PMOD attached. It samples the external `sck`, `cs` and `mosi` on the 50 MHz system clock, shifts in one `WIDTH`-bit frame MSB-first, and shifts out a preloaded response word on `miso`. It sits between the bus pins (or the master's pins in loopback) and a local register block that supplies the reply and consumes the received command.

## Interface
- `WIDTH`, 40: frame length in bits.
- `SYNC_STAGES`, 2: synchronizer depth on `sck`, `cs` and `mosi` (minimum 2).
- `clk`  input  1  50 MHz system clock; all logic is on its rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `tx_bytes`  input  WIDTH  reply word; captured at frame start.
- `rx_bytes`  output  WIDTH  last complete received frame.
- `rx_valid`  output  1  one-cycle pulse when `rx_bytes` updates.
- `frame_err`  output  1  one-cycle pulse on a short frame (`cs` released before WIDTH bits).
- `overrun`  output  1  sticky; set when more than WIDTH rising `sck` edges occur in one frame; cleared at the next frame start.
- `busy`  output  1  high while a frame is in progress.
- `cs`  input  1  active-low chip select from the master.
- `sck`  input  1  SPI clock; ignored while `cs` is high.
- `mosi`  input  1  master-out data.
- `miso`  output  1  slave-out data.
- `miso_oe`  output  1  output enable for the `miso` pad; equals the synchronized `~cs`.

## Operation
- All three bus inputs pass through `SYNC_STAGES` flops. One further register provides edge detection: `sck_rise`, `sck_fall`, `cs_fall`, `cs_rise`.
- The FSM has three states:
  - IDLE: waits for `cs_fall`.
  - SHIFT: counts bits.
  - HOLD: WIDTH bits are done; waits for `cs_rise`.
- IDLE, on `cs_fall`:
  - load `tx_sr <= tx_bytes`, clear `bit_cnt` and `overrun`;
  - drive `miso = tx_bytes[WIDTH-1]` (CPHA=0: first bit valid before the first rising edge);
  - go to SHIFT.
- SHIFT, on `sck_rise`: `rx_sr <= {rx_sr[WIDTH-2:0], mosi_s}` and `bit_cnt++`.
  - When `bit_cnt` reaches WIDTH: `rx_bytes <= next rx_sr`, pulse `rx_valid`, go to HOLD.
- SHIFT, on `sck_fall`: `tx_sr <= tx_sr << 1`, zero-filled. `miso` is always `tx_sr[WIDTH-1]`.
- SHIFT, on `cs_rise` with `bit_cnt < WIDTH`: pulse `frame_err`, leave `rx_bytes` unchanged, go to IDLE.
- HOLD:
  - `sck_rise` sets `overrun`; `miso` holds 0; `rx_sr` is frozen.
  - `cs_rise` returns to IDLE.
- `cs_fall` and `sck_rise` in the same cycle: `cs_fall` wins. The edge is not counted, since in mode 0 `sck` is low when `cs` falls.
- `busy` is 1 in SHIFT and HOLD.
- `bit_cnt` width is `$clog2(WIDTH+1)`; it never wraps.

## Timing
- Reset values:
  - `rx_bytes=0`, `rx_valid=0`, `frame_err=0`, `overrun=0`, `busy=0`;
  - `miso=0`, `miso_oe=0`;
  - state IDLE, synchronizers all 1 for `cs` and 0 for `sck`/`mosi`.
- Input-to-action latency is `SYNC_STAGES+1` clk cycles (3 by default) from a pin edge to the internal edge strobe.
- `miso` changes one clk after the strobe: 4 clk, 80 ns at default settings, after pin `sck` falls or `cs` falls.
- Each `sck` half-period must be at least 8 clk cycles, i.e. `sck` ≤ 3.125 MHz. The master's 781.25 kHz satisfies this with margin.
- `rx_valid` asserts 4 clk after the WIDTH-th rising `sck` at the pin.
- `rst_n` low mid-frame forces IDLE immediately. After release, the block waits for a fresh `cs_fall`; a `cs` that is already low is ignored until it goes high and falls again.

## Structure
- Shared package `spi_pkg`:
  - `SPI_FRAME_BITS = 40`;
  - state enum `spi_rsp_state_t {IDLE, SHIFT, HOLD}`;
  - `SPI_SYNC_STAGES = 2`.
- One sub-module, `spi_sync_edge`: a parameterized-depth synchronizer that outputs `level`, `rise` and `fall`. It is instanced three times (`cs`, `sck`, `mosi`; the `mosi` instance uses `level` only).

## Test plan
- Normal frame, `tx_bytes=40'hA5_0F_F0_3C_81`, master sends `40'h12_34_56_78_9A` at 781 kHz:
  - `rx_bytes=40'h123456789A` with a single `rx_valid`;
  - sampled `miso` sequence equals `A50FF03C81`;
  - `frame_err=0`.
- Short frame: `cs` released after 17 bits -> one `frame_err` pulse, no `rx_valid`, `rx_bytes` keeps its prior value, `busy` drops 4 clk after `cs` rises.
- Overrun: 43 `sck` pulses in one frame -> `rx_valid` after pulse 40, `overrun=1` from pulse 41, `miso=0` after bit 40. The next `cs_fall` clears `overrun`.
- Back-to-back frames with `cs` high for 10 clk between them, `tx_bytes` changed in the gap to `40'hFF_FF_00_00_01` -> the second frame outputs the new word and both `rx_valid` pulses occur.
- Reset mid-frame: `rst_n` low at bit 20 with `cs` held low afterwards:
  - all outputs return to reset values;
  - no `rx_valid` until `cs` toggles high then low and a full frame follows.
- Loopback with the existing 40-bit SPI master (`trigger` pulse, `out_bytes=40'h00_00_00_00_C3`):
  - master `in_bytes` equals the responder's `tx_bytes`;
  - responder `rx_bytes=40'hC3`.
